// File: rtl/max7219_pkg.sv
// max7219_pkg
// Shared definitions for the MAX7219 display sequencer: register address
// constants, the sequencer and transmitter state enums, and the 16-bit
// command word layout {pad[15:12]=0, addr[11:8], data[7:0]}.
// No ports (package).
package max7219_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam int unsigned INIT_LEN = 6;

    typedef enum logic [2:0] {
        ST_RESET_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SEND_INT,
        ST_SEND_ROW
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SHIFT,
        TX_GAP
    } tx_phase_t;

    typedef struct packed {
        logic [3:0] pad;
        logic [3:0] addr;
        logic [7:0] data;
    } word_t;

    function automatic word_t make_word(input logic [3:0] addr, input logic [7:0] data);
        word_t w;
        w.pad  = 4'h0;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

endpackage

// File: rtl/max7219_sequencer_if.sv
// max7219_sequencer_if
// Bundles the fabric-side frame-buffer write bus and intensity input with the
// MAX7219 pin outputs and status flags.
//   wr_en/wr_addr/wr_data : frame-buffer row write (fabric -> sequencer)
//   intensity             : brightness level, sampled every cycle
//   dout/ce/clockout      : DIN / LOAD / CLK pins (sequencer -> display)
//   init_done/busy        : status (sequencer -> fabric)
// Modports: master = fabric side, slave = sequencer side.
interface max7219_sequencer_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [3:0] intensity;
    logic       dout;
    logic       ce;
    logic       clockout;
    logic       init_done;
    logic       busy;

    modport master (
        output wr_en, wr_addr, wr_data, intensity,
        input  dout, ce, clockout, init_done, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, intensity,
        output dout, ce, clockout, init_done, busy
    );
endinterface

// File: rtl/max7219_spi_tx.sv
// max7219_spi_tx
// Serialises one 16-bit command word MSB first onto dout/clockout, framed by
// ce (LOAD) low. Each bit: clockout low CLK_DIV cycles, then high CLK_DIV
// cycles; dout changes only at the start of the low half. After the last bit
// ce returns high and the transmitter stays unavailable for CLK_DIV cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : issue word (accepted only while ready=1)
//   word       : command word, latched when start is accepted
//   ready      : transmitter idle, may accept start this cycle
//   done       : last cycle of the post-word ce-high gap
//   dout, ce, clockout : registered pin outputs
module max7219_spi_tx
    import max7219_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    input  word_t word,
    output logic  ready,
    output logic  done,
    output logic  dout,
    output logic  ce,
    output logic  clockout
);

    localparam logic [8:0] HALF = 9'(CLK_DIV);
    localparam logic [8:0] FULL = 9'(2 * CLK_DIV);

    tx_phase_t   phase, phase_n;
    logic [15:0] shreg, shreg_n;
    logic [8:0]  tick, tick_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic        dout_q, dout_n;
    logic        ce_q, ce_n;
    logic        clk_q, clk_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= TX_IDLE;
            shreg   <= '0;
            tick    <= '0;
            bit_cnt <= '0;
            dout_q  <= 1'b0;
            ce_q    <= 1'b1;
            clk_q   <= 1'b0;
        end else begin
            phase   <= phase_n;
            shreg   <= shreg_n;
            tick    <= tick_n;
            bit_cnt <= bit_cnt_n;
            dout_q  <= dout_n;
            ce_q    <= ce_n;
            clk_q   <= clk_n;
        end
    end

    always_comb begin
        phase_n   = phase;
        shreg_n   = shreg;
        tick_n    = tick;
        bit_cnt_n = bit_cnt;
        dout_n    = dout_q;
        ce_n      = ce_q;
        clk_n     = clk_q;
        unique case (phase)
            TX_IDLE: begin
                if (start) begin
                    phase_n   = TX_SHIFT;
                    shreg_n   = word;
                    dout_n    = word[15];
                    ce_n      = 1'b0;
                    clk_n     = 1'b0;
                    tick_n    = '0;
                    bit_cnt_n = '0;
                end
            end
            TX_SHIFT: begin
                tick_n = tick + 9'd1;
                if (tick == HALF - 9'd1) begin
                    clk_n = 1'b1;
                end
                // End of a bit period: drop the clock and present the next bit,
                // or close the frame after bit 0.
                if (tick == FULL - 9'd1) begin
                    tick_n = '0;
                    clk_n  = 1'b0;
                    if (bit_cnt == 4'd15) begin
                        phase_n = TX_GAP;
                        ce_n    = 1'b1;
                        dout_n  = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        shreg_n   = {shreg[14:0], 1'b0};
                        dout_n    = shreg[14];
                    end
                end
            end
            TX_GAP: begin
                tick_n = tick + 9'd1;
                if (tick == HALF - 9'd1) begin
                    tick_n  = '0;
                    phase_n = TX_IDLE;
                end
            end
            default: phase_n = TX_IDLE;
        endcase
    end

    assign ready    = (phase == TX_IDLE);
    assign done     = (phase == TX_GAP) && (tick == HALF - 9'd1);
    assign dout     = dout_q;
    assign ce       = ce_q;
    assign clockout = clk_q;

endmodule

// File: rtl/max7219_sequencer.sv
// max7219_sequencer
// Drives one MAX7219 8x8 matrix: runs the six-word power-up configuration,
// then sends intensity changes (first priority) and dirty frame-buffer rows
// (lowest row first). Buffer writes never stall.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : max7219_sequencer_if.slave
//                wr_en/wr_addr/wr_data, intensity in;
//                dout/ce/clockout, init_done, busy out
// Parameters: CLK_DIV (cycles per clockout half period, 2..255),
//             SCAN_LIMIT (value for register 0x0B).
module max7219_sequencer
    import max7219_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SCAN_LIMIT = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    max7219_sequencer_if.slave   bus
);

    seq_state_t state, state_n;
    logic [2:0] init_idx, init_idx_n;
    logic [3:0] shadow, shadow_n;
    logic       done_q, done_n;
    logic [7:0] frame [8];
    logic [7:0] dirty;

    logic       tx_start;
    word_t      tx_word;
    logic       tx_ready;
    logic       tx_done;
    logic       row_issue;
    logic [2:0] row_sel;
    word_t      init_word;

    max7219_spi_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tx_start),
        .word     (tx_word),
        .ready    (tx_ready),
        .done     (tx_done),
        .dout     (bus.dout),
        .ce       (bus.ce),
        .clockout (bus.clockout)
    );

    always_comb begin
        row_sel = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (dirty[i-1]) begin
                row_sel = 3'(i - 1);
            end
        end
    end

    always_comb begin
        unique case (init_idx)
            3'd0:    init_word = make_word(REG_SHUTDOWN, 8'h00);
            3'd1:    init_word = make_word(REG_TEST, 8'h00);
            3'd2:    init_word = make_word(REG_DECODE, 8'h00);
            3'd3:    init_word = make_word(REG_SCANLIM, 8'(SCAN_LIMIT));
            3'd4:    init_word = make_word(REG_INTENSITY, {4'h0, bus.intensity});
            3'd5:    init_word = make_word(REG_SHUTDOWN, 8'h01);
            default: init_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET_WAIT;
            init_idx <= '0;
            shadow   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            init_idx <= init_idx_n;
            shadow   <= shadow_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        init_idx_n = init_idx;
        shadow_n   = shadow;
        done_n     = done_q;
        tx_start   = 1'b0;
        tx_word    = '0;
        row_issue  = 1'b0;
        unique case (state)
            ST_RESET_WAIT: begin
                state_n    = ST_INIT;
                init_idx_n = '0;
            end
            ST_INIT: begin
                if (init_idx < 3'(INIT_LEN)) begin
                    if (tx_ready) begin
                        tx_start   = 1'b1;
                        tx_word    = init_word;
                        init_idx_n = init_idx + 3'd1;
                        // The intensity sent during init becomes the shadow so
                        // it is not re-sent once idle.
                        if (init_idx == 3'd4) begin
                            shadow_n = bus.intensity;
                        end
                    end
                end else if (tx_done) begin
                    // Leave init in the cycle the sixth word's gap ends so the
                    // first scheduled word can start back-to-back.
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (tx_ready) begin
                    if (bus.intensity != shadow) begin
                        tx_start = 1'b1;
                        tx_word  = make_word(REG_INTENSITY, {4'h0, bus.intensity});
                        shadow_n = bus.intensity;
                        state_n  = ST_SEND_INT;
                    end else if (|dirty) begin
                        tx_start  = 1'b1;
                        tx_word   = make_word({1'b0, row_sel} + REG_DIGIT0, frame[row_sel]);
                        row_issue = 1'b1;
                        state_n   = ST_SEND_ROW;
                    end
                end
            end
            ST_SEND_INT, ST_SEND_ROW: begin
                if (tx_done) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_RESET_WAIT;
        endcase
    end

    // A write to the row being issued lands after the clear, so the row stays
    // dirty and its new data goes out on a later word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                frame[i] <= '0;
            end
            dirty <= '1;
        end else begin
            if (row_issue) begin
                dirty[row_sel] <= 1'b0;
            end
            if (bus.wr_en) begin
                frame[bus.wr_addr] <= bus.wr_data;
                dirty[bus.wr_addr] <= 1'b1;
            end
        end
    end

    assign bus.init_done = done_q;
    assign bus.busy      = ~tx_ready;

endmodule

// File: tb/tb_max7219_sequencer.sv
// tb_max7219_sequencer
// Self-checking bench: a pin-level decoder rebuilds each 16-bit word from
// dout/clockout/ce and compares it against words predicted by a cycle-level
// reference model of the scheduling rules (init list, intensity priority,
// lowest dirty row, fixed word period).
module tb_max7219_sequencer;

    localparam int unsigned CD = 2;
    localparam int unsigned SL = 7;
    localparam int P = 33 * CD + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    max7219_sequencer_if bus();

    max7219_sequencer #(
        .CLK_DIV    (CD),
        .SCAN_LIMIT (SL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_frame [8];
    logic [7:0]  m_dirty;
    logic [3:0]  m_shadow;
    int          m_init_idx;
    int          c;
    int          last_start;
    int          ready_at;
    int          done_at;
    int          rise_cyc;
    logic [3:0]  cur_int;
    logic [15:0] exp_q [$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_frame[i] = 8'h00;
        m_dirty    = 8'hFF;
        m_shadow   = 4'h0;
        m_init_idx = 0;
        c          = 0;
        last_start = -1000000;
        ready_at   = 1;
        done_at    = 1 << 30;
        rise_cyc   = -1;
        exp_q.delete();
    endtask

    function automatic logic [15:0] init_list(input int idx, input logic [3:0] inten);
        logic [15:0] w;
        case (idx)
            0:       w = 16'h0C00;
            1:       w = 16'h0F00;
            2:       w = 16'h0900;
            3:       w = 16'h0B00 | 16'(SL);
            4:       w = {12'h0A0, inten};
            default: w = 16'h0C01;
        endcase
        return w;
    endfunction

    function automatic bit pending();
        return (m_init_idx < 6) || (cur_int != m_shadow) || (m_dirty != 8'h00) || (c < ready_at);
    endfunction

    // One cycle: check outputs of cycle c, advance the model with this cycle's
    // inputs, drive them, and move to the next cycle's negedge.
    task automatic cyc(input logic we, input logic [2:0] a, input logic [7:0] d);
        int r;
        check_eq("busy", 32'(bus.busy), 32'(c > last_start && c < last_start + P));
        check_eq("init_done", 32'(bus.init_done), 32'(c >= done_at));
        if (bus.init_done === 1'b1 && rise_cyc < 0) rise_cyc = c;
        if (c >= ready_at) begin
            if (m_init_idx < 6) begin
                exp_q.push_back(init_list(m_init_idx, cur_int));
                if (m_init_idx == 4) m_shadow = cur_int;
                m_init_idx++;
                last_start = c;
                ready_at   = c + P;
                if (m_init_idx == 6) done_at = c + P;
            end else if (cur_int != m_shadow) begin
                m_shadow = cur_int;
                exp_q.push_back({12'h0A0, cur_int});
                last_start = c;
                ready_at   = c + P;
            end else if (m_dirty != 8'h00) begin
                r = 0;
                for (int i = 7; i >= 0; i--) if (m_dirty[i]) r = i;
                exp_q.push_back({4'h0, 4'(r + 1), m_frame[r]});
                m_dirty[r] = 1'b0;
                last_start = c;
                ready_at   = c + P;
            end
        end
        if (we) begin
            m_frame[a] = d;
            m_dirty[a] = 1'b1;
        end
        bus.wr_en     = we;
        bus.wr_addr   = a;
        bus.wr_data   = d;
        bus.intensity = cur_int;
        @(posedge clk);
        c++;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            cyc(1'b0, 3'd0, 8'h00);
            n++;
        end
        if (n >= budget) check_eq("drain_timeout", 32'(n), 32'(budget + 1));
        for (int i = 0; i < 6; i++) cyc(1'b0, 3'd0, 8'h00);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic release_reset();
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- pin-level decoder ----------------
    logic [15:0] dec_sh   = '0;
    int          dec_bits = 0;
    logic        prev_ce  = 1'b1;
    logic        prev_ck  = 1'b0;

    always @(negedge clk) begin
        if (bus.ce === 1'b1 && prev_ce === 1'b0) begin
            if (dec_bits == 16) begin
                if (exp_q.size() == 0) check_eq("word_extra", 32'(dec_sh), 32'hFFFF_FFFF);
                else check_eq("word", 32'(dec_sh), 32'(exp_q.pop_front()));
            end
            dec_bits = 0;
        end
        if (bus.ce === 1'b0 && prev_ce === 1'b1) dec_bits = 0;
        if (bus.clockout === 1'b1 && prev_ck === 1'b0 && bus.ce === 1'b0) begin
            dec_sh = {dec_sh[14:0], bus.dout};
            dec_bits++;
        end
        prev_ce = bus.ce;
        prev_ck = bus.clockout;
    end

    // ---------------- stimulus ----------------
    initial begin
        int ct;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        cur_int       = 4'd5;
        bus.intensity = cur_int;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_ce", 32'(bus.ce), 32'd1);
        check_eq("rst_clockout", 32'(bus.clockout), 32'd0);
        check_eq("rst_dout", 32'(bus.dout), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_init_done", 32'(bus.init_done), 32'd0);

        // Power-up sequence and the eight initial row words.
        release_reset();
        drain(4000);
        check_eq("init_rise_cycle", 32'(rise_cyc), 32'(1 + 6 * P));

        // Single row write.
        cyc(1'b1, 3'd3, 8'hA5);
        drain(1000);

        // Rows 6,1,6 written while an intensity word is in flight.
        cur_int = 4'd7;
        cyc(1'b0, 3'd0, 8'h00);
        cyc(1'b1, 3'd6, 8'h11);
        cyc(1'b1, 3'd1, 8'h22);
        cyc(1'b1, 3'd6, 8'h33);
        drain(1000);

        // Intensity change and row 0 write in the same cycle.
        cur_int = 4'd9;
        cyc(1'b1, 3'd0, 8'h01);
        drain(1000);

        // Row 2 rewritten in the cycle its word starts.
        cyc(1'b1, 3'd2, 8'h5A);
        cyc(1'b1, 3'd2, 8'hC3);
        drain(1000);

        // Randomised writes and intensity changes.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 39) == 0) cur_int = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        drain(4000);

        // Reset in the middle of bit 7 of the second init word.
        rst_n = 1'b0;
        @(negedge clk);
        cur_int = 4'd3;
        release_reset();
        ct = 1 + P + 1 + 15 * CD;
        while (c < ct) cyc(1'b0, 3'd0, 8'h00);
        check_eq("mid_bit_clockout", 32'(bus.clockout), 32'd1);
        check_eq("mid_bit_ce", 32'(bus.ce), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_ce", 32'(bus.ce), 32'd1);
        check_eq("abort_clockout", 32'(bus.clockout), 32'd0);
        check_eq("abort_dout", 32'(bus.dout), 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        release_reset();
        drain(4000);
        check_eq("reinit_rise_cycle", 32'(rise_cyc), 32'(1 + 6 * P));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
